// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: bundles the raw PS/2 pins and the Hack keyboard-side
// outputs. The master modport is the keyboard/pin side (drives the raw
// PS/2 lines and observes the result). The slave modport is the decoder.
interface ps2_keyboard_if;
  logic        ps2Clk;
  logic        ps2Data;
  logic [15:0] outKeyboard;
  logic        frameErr;

  modport master (
    output ps2Clk,
    output ps2Data,
    input  outKeyboard,
    input  frameErr
  );

  modport slave (
    input  ps2Clk,
    input  ps2Data,
    output outKeyboard,
    output frameErr
  );
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 scan-code set 2 receiver for the Hack keyboard register
// (address 24576). It synchronizes and glitch-filters the PS/2 clock, frames
// bytes (start, 8 data LSB first, odd parity, stop), tracks E0/F0 prefixes
// and holds the Hack code of the most recently pressed key until that key
// is released.
// Optional feature macro: PS2_SHIFT_EN (left/right shift tracking, lower
// case letters by default and US-layout shifted symbols while shift is held).
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_keyboard_if.slave kbd
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Translate a set-2 key identity into a Hack code; 0 means unmapped.
  // lo is the unshifted character, hi the shifted one.
  function automatic logic [15:0] key_map(input logic e0, input logic [7:0] code,
                                          input logic sh);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'd0;
    hi = 8'd0;
    if (e0) begin
      case (code)
        8'h6B:   {lo, hi} = {8'd130, 8'd130};
        8'h75:   {lo, hi} = {8'd131, 8'd131};
        8'h74:   {lo, hi} = {8'd132, 8'd132};
        8'h72:   {lo, hi} = {8'd133, 8'd133};
        8'h6C:   {lo, hi} = {8'd134, 8'd134};
        8'h69:   {lo, hi} = {8'd135, 8'd135};
        8'h7D:   {lo, hi} = {8'd136, 8'd136};
        8'h7A:   {lo, hi} = {8'd137, 8'd137};
        8'h70:   {lo, hi} = {8'd138, 8'd138};
        8'h71:   {lo, hi} = {8'd139, 8'd139};
        8'h5A:   {lo, hi} = {8'd128, 8'd128};
        8'h4A:   {lo, hi} = {8'd47,  8'd47};
        default: {lo, hi} = {8'd0,   8'd0};
      endcase
    end else begin
      case (code)
        8'h1C:   {lo, hi} = {8'd97,  8'd65};
        8'h32:   {lo, hi} = {8'd98,  8'd66};
        8'h21:   {lo, hi} = {8'd99,  8'd67};
        8'h23:   {lo, hi} = {8'd100, 8'd68};
        8'h24:   {lo, hi} = {8'd101, 8'd69};
        8'h2B:   {lo, hi} = {8'd102, 8'd70};
        8'h34:   {lo, hi} = {8'd103, 8'd71};
        8'h33:   {lo, hi} = {8'd104, 8'd72};
        8'h43:   {lo, hi} = {8'd105, 8'd73};
        8'h3B:   {lo, hi} = {8'd106, 8'd74};
        8'h42:   {lo, hi} = {8'd107, 8'd75};
        8'h4B:   {lo, hi} = {8'd108, 8'd76};
        8'h3A:   {lo, hi} = {8'd109, 8'd77};
        8'h31:   {lo, hi} = {8'd110, 8'd78};
        8'h44:   {lo, hi} = {8'd111, 8'd79};
        8'h4D:   {lo, hi} = {8'd112, 8'd80};
        8'h15:   {lo, hi} = {8'd113, 8'd81};
        8'h2D:   {lo, hi} = {8'd114, 8'd82};
        8'h1B:   {lo, hi} = {8'd115, 8'd83};
        8'h2C:   {lo, hi} = {8'd116, 8'd84};
        8'h3C:   {lo, hi} = {8'd117, 8'd85};
        8'h2A:   {lo, hi} = {8'd118, 8'd86};
        8'h1D:   {lo, hi} = {8'd119, 8'd87};
        8'h22:   {lo, hi} = {8'd120, 8'd88};
        8'h35:   {lo, hi} = {8'd121, 8'd89};
        8'h1A:   {lo, hi} = {8'd122, 8'd90};
        8'h45:   {lo, hi} = {8'd48,  8'd41};
        8'h16:   {lo, hi} = {8'd49,  8'd33};
        8'h1E:   {lo, hi} = {8'd50,  8'd64};
        8'h26:   {lo, hi} = {8'd51,  8'd35};
        8'h25:   {lo, hi} = {8'd52,  8'd36};
        8'h2E:   {lo, hi} = {8'd53,  8'd37};
        8'h36:   {lo, hi} = {8'd54,  8'd94};
        8'h3D:   {lo, hi} = {8'd55,  8'd38};
        8'h3E:   {lo, hi} = {8'd56,  8'd42};
        8'h46:   {lo, hi} = {8'd57,  8'd40};
        8'h0E:   {lo, hi} = {8'd96,  8'd126};
        8'h4E:   {lo, hi} = {8'd45,  8'd95};
        8'h55:   {lo, hi} = {8'd61,  8'd43};
        8'h54:   {lo, hi} = {8'd91,  8'd123};
        8'h5B:   {lo, hi} = {8'd93,  8'd125};
        8'h5D:   {lo, hi} = {8'd92,  8'd124};
        8'h4C:   {lo, hi} = {8'd59,  8'd58};
        8'h52:   {lo, hi} = {8'd39,  8'd34};
        8'h41:   {lo, hi} = {8'd44,  8'd60};
        8'h49:   {lo, hi} = {8'd46,  8'd62};
        8'h4A:   {lo, hi} = {8'd47,  8'd63};
        8'h29:   {lo, hi} = {8'd32,  8'd32};
        8'h5A:   {lo, hi} = {8'd128, 8'd128};
        8'h66:   {lo, hi} = {8'd129, 8'd129};
        8'h76:   {lo, hi} = {8'd140, 8'd140};
        8'h05:   {lo, hi} = {8'd141, 8'd141};
        8'h06:   {lo, hi} = {8'd142, 8'd142};
        8'h04:   {lo, hi} = {8'd143, 8'd143};
        8'h0C:   {lo, hi} = {8'd144, 8'd144};
        8'h03:   {lo, hi} = {8'd145, 8'd145};
        8'h0B:   {lo, hi} = {8'd146, 8'd146};
        8'h83:   {lo, hi} = {8'd147, 8'd147};
        8'h0A:   {lo, hi} = {8'd148, 8'd148};
        8'h01:   {lo, hi} = {8'd149, 8'd149};
        8'h09:   {lo, hi} = {8'd150, 8'd150};
        8'h78:   {lo, hi} = {8'd151, 8'd151};
        8'h07:   {lo, hi} = {8'd152, 8'd152};
        // keypad: digits and operators, not affected by shift
        8'h70:   {lo, hi} = {8'd48,  8'd48};
        8'h69:   {lo, hi} = {8'd49,  8'd49};
        8'h72:   {lo, hi} = {8'd50,  8'd50};
        8'h7A:   {lo, hi} = {8'd51,  8'd51};
        8'h6B:   {lo, hi} = {8'd52,  8'd52};
        8'h73:   {lo, hi} = {8'd53,  8'd53};
        8'h74:   {lo, hi} = {8'd54,  8'd54};
        8'h6C:   {lo, hi} = {8'd55,  8'd55};
        8'h75:   {lo, hi} = {8'd56,  8'd56};
        8'h7D:   {lo, hi} = {8'd57,  8'd57};
        8'h71:   {lo, hi} = {8'd46,  8'd46};
        8'h7C:   {lo, hi} = {8'd42,  8'd42};
        8'h7B:   {lo, hi} = {8'd45,  8'd45};
        8'h79:   {lo, hi} = {8'd43,  8'd43};
        default: {lo, hi} = {8'd0,   8'd0};
      endcase
    end
`ifdef PS2_SHIFT_EN
    key_map = {8'd0, sh ? hi : lo};
`else
    // without shift tracking letters are always upper case
    key_map = {8'd0, (sh || ((lo >= 8'd97) && (lo <= 8'd122))) ? hi : lo};
`endif
  endfunction

  // Flops
  logic [1:0]    sync_clk_q, sync_clk_d;
  logic [1:0]    sync_dat_q, sync_dat_d;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_reg_q, shift_reg_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   out_q, out_d;
  logic          e0_q, e0_d;
  logic          f0_q, f0_d;
`ifdef PS2_SHIFT_EN
  logic          lshift_q, lshift_d;
  logic          rshift_q, rshift_d;
`endif

  // Combinational helpers
  logic          fall_s;
  logic          data_s;
  logic          byte_vld_s;
  logic          err_s;
  logic [15:0]   key_plain_s;
  logic [15:0]   key_shift_s;
  logic [15:0]   key_now_s;

  assign data_s = sync_dat_q[1];

  // Two-flop synchronizers for the raw PS/2 pins
  always_comb begin
    sync_clk_d = {sync_clk_q[0], kbd.ps2Clk};
    sync_dat_d = {sync_dat_q[0], kbd.ps2Data};
  end

  // Glitch filter: flip the filtered clock after FILTER_LEN differing samples
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (sync_clk_q[1] == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_LAST) begin
      filt_clk_d = ~filt_clk_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  assign fall_s = filt_clk_q & ~filt_clk_d;

  // Frame FSM with mid-frame timeout
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    err_s       = 1'b0;
    byte_vld_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall_s) begin
          shift_reg_d = {data_s, shift_reg_q[7:1]};
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall_s) begin
          parity_d = data_s;
          state_d  = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall_s) begin
          if (data_s && (^{shift_reg_q, parity_q})) begin
            byte_vld_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_d   = S_IDLE;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 4'd0;
      end
    endcase
    // the timeout only runs while a frame is in progress
    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else if (fall_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      err_s     = 1'b1;
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    frame_err_d = err_s;
  end

  // Key identity lookups for the byte currently in the shift register
  always_comb begin
    key_plain_s = key_map(e0_q, shift_reg_q, 1'b0);
`ifdef PS2_SHIFT_EN
    key_shift_s = key_map(e0_q, shift_reg_q, 1'b1);
    key_now_s   = (lshift_q | rshift_q) ? key_shift_s : key_plain_s;
`else
    key_shift_s = key_plain_s;
    key_now_s   = key_plain_s;
`endif
  end

  // Byte decode: prefixes, make/break handling and shift bookkeeping
  always_comb begin
    out_d = out_q;
    e0_d  = e0_q;
    f0_d  = f0_q;
`ifdef PS2_SHIFT_EN
    lshift_d = lshift_q;
    rshift_d = rshift_q;
`endif
    if (byte_vld_s) begin
      if (shift_reg_q == 8'hE0) begin
        e0_d = 1'b1;
      end else if (shift_reg_q == 8'hF0) begin
        f0_d = 1'b1;
      end else begin
        e0_d = 1'b0;
        f0_d = 1'b0;
        if (f0_q) begin
          // a release clears only if it is the key currently shown,
          // whichever shift state it was pressed under
          if ((key_plain_s != 16'd0) &&
              ((out_q == key_plain_s) || (out_q == key_shift_s))) begin
            out_d = 16'd0;
          end else begin
            out_d = out_q;
          end
        end else if (key_now_s != 16'd0) begin
          out_d = key_now_s;
        end else begin
          out_d = out_q;
        end
`ifdef PS2_SHIFT_EN
        if (!e0_q && (shift_reg_q == 8'h12)) begin
          lshift_d = ~f0_q;
        end else if (!e0_q && (shift_reg_q == 8'h59)) begin
          rshift_d = ~f0_q;
        end else begin
          lshift_d = lshift_q;
          rshift_d = rshift_q;
        end
`endif
      end
    end else begin
      out_d = out_q;
    end
  end

  // State registers; synchronous reset returns everything to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_clk_q  <= 2'b11;
      sync_dat_q  <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_reg_q <= 8'd0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      out_q       <= 16'd0;
      e0_q        <= 1'b0;
      f0_q        <= 1'b0;
    end else begin
      sync_clk_q  <= sync_clk_d;
      sync_dat_q  <= sync_dat_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      out_q       <= out_d;
      e0_q        <= e0_d;
      f0_q        <= f0_d;
    end
  end

`ifdef PS2_SHIFT_EN
  // Shift key state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
    end else begin
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
    end
  end
`endif

  assign kbd.outKeyboard = out_q;
  assign kbd.frameErr    = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: drives PS/2 frames into ps2_keyboard and compares the
// Hack key code against a table-driven key model held in the bench.
module tb_ps2_keyboard;
  localparam int HALF = 16;
  localparam int TO   = 1000;
`ifdef PS2_SHIFT_EN
  localparam int A_CODE = 97;
  localparam int B_CODE = 98;
`else
  localparam int A_CODE = 65;
  localparam int B_CODE = 66;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  ps2_keyboard_if kbd();

  ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .kbd  (kbd.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // frameErr monitor: total high cycles and pulses longer than one clock
  int   err_cycles = 0;
  int   err_long = 0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (kbd.frameErr === 1'b1) begin
      err_cycles++;
      if (err_prev) err_long++;
    end
    err_prev = (kbd.frameErr === 1'b1);
  end

  // ---------------- reference key model ----------------
  int lo_tab[0:511];
  int hi_tab[0:511];
  int m_out = 0;
  bit m_e0 = 1'b0;
  bit m_f0 = 1'b0;
`ifdef PS2_SHIFT_EN
  bit m_lsh = 1'b0;
  bit m_rsh = 1'b0;
`endif

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
  logic [7:0] pun_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
      8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] fn_codes [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83,
      8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  logic [7:0] kp_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74,
      8'h6C, 8'h75, 8'h7D};
  logic [7:0] nav_codes [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D,
      8'h7A, 8'h70, 8'h71};
  int dig_hi [10] = '{41, 33, 64, 35, 36, 37, 94, 38, 42, 40};
  int pun_lo [11] = '{96, 45, 61, 91, 93, 92, 59, 39, 44, 46, 47};
  int pun_hi [11] = '{126, 95, 43, 123, 125, 124, 58, 34, 60, 62, 63};

  task automatic set_key(input int idx, input int lo, input int hi);
    lo_tab[idx] = lo;
    hi_tab[idx] = hi;
  endtask

  task automatic init_map();
    for (int i = 0; i < 512; i++) set_key(i, 0, 0);
    for (int i = 0; i < 26; i++) set_key(int'(let_codes[i]), 97 + i, 65 + i);
    for (int i = 0; i < 10; i++) set_key(int'(dig_codes[i]), 48 + i, dig_hi[i]);
    for (int i = 0; i < 11; i++) set_key(int'(pun_codes[i]), pun_lo[i], pun_hi[i]);
    for (int i = 0; i < 12; i++) set_key(int'(fn_codes[i]), 141 + i, 141 + i);
    for (int i = 0; i < 10; i++) set_key(int'(kp_codes[i]), 48 + i, 48 + i);
    for (int i = 0; i < 10; i++) set_key(256 + int'(nav_codes[i]), 130 + i, 130 + i);
    set_key('h29, 32, 32);   set_key('h5A, 128, 128);
    set_key('h66, 129, 129); set_key('h76, 140, 140);
    set_key('h71, 46, 46);   set_key('h7C, 42, 42);
    set_key('h7B, 45, 45);   set_key('h79, 43, 43);
    set_key(256 + 'h5A, 128, 128); set_key(256 + 'h4A, 47, 47);
  endtask

  function automatic int tb_code(input bit e0, input logic [7:0] b, input bit sh);
    int v;
    v = sh ? hi_tab[{e0, b}] : lo_tab[{e0, b}];
`ifndef PS2_SHIFT_EN
    if (v >= 97 && v <= 122) v = v - 32;
`endif
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int p, s, c;
    if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'hF0) m_f0 = 1'b1;
    else begin
      p = tb_code(m_e0, b, 1'b0);
`ifdef PS2_SHIFT_EN
      s = tb_code(m_e0, b, 1'b1);
      c = tb_code(m_e0, b, m_lsh || m_rsh);
      if (!m_e0 && b == 8'h12) m_lsh = !m_f0;
      if (!m_e0 && b == 8'h59) m_rsh = !m_f0;
`else
      s = p;
      c = p;
`endif
      if (m_f0) begin
        if (p != 0 && (m_out == p || m_out == s)) m_out = 0;
      end else if (c != 0) begin
        m_out = c;
      end
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
  endtask

  // ---------------- PS/2 line driver ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch,
                            input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      wait_clk(HALF / 2);
      kbd.ps2Data = bits[i];
      if (glitch && i == 4) begin
        kbd.ps2Clk = 1'b0;
        wait_clk(1);
        kbd.ps2Clk = 1'b1;
        wait_clk(HALF / 2 - 1);
      end else begin
        wait_clk(HALF / 2);
      end
      kbd.ps2Clk = 1'b0;
      wait_clk(HALF);
      kbd.ps2Clk = 1'b1;
    end
    wait_clk(HALF / 2);
    kbd.ps2Data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
    model_byte(b);
    wait_clk(20);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    kbd.ps2Clk = 1'b1;
    kbd.ps2Data = 1'b1;
    reset = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(3);
    @(negedge clk);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL reset_out: got %0d want 0", kbd.outKeyboard);
    end
    total++;
    if (kbd.frameErr !== 1'b0) begin
      bad++; $display("FAIL reset_err: got %b want 0", kbd.frameErr);
    end
  endtask

  task automatic test_make_break();
    int e0c = err_cycles;
    send_byte(8'h1C);
    total++;
    if (kbd.outKeyboard !== 16'(A_CODE)) begin
      bad++; $display("FAIL make_a: got %0d want %0d", kbd.outKeyboard, A_CODE);
    end
    send_byte(8'hF0);
    total++;
    if (kbd.outKeyboard !== 16'(A_CODE)) begin
      bad++; $display("FAIL f0_hold: got %0d want %0d", kbd.outKeyboard, A_CODE);
    end
    send_byte(8'h1C);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL break_a: got %0d want 0", kbd.outKeyboard);
    end
    total++;
    if (err_cycles != e0c) begin
      bad++; $display("FAIL make_break_err: got %0d err cycles want 0", err_cycles - e0c);
    end
  endtask

  task automatic test_e0();
    send_byte(8'hE0);
    send_byte(8'h6B);
    total++;
    if (kbd.outKeyboard !== 16'd130) begin
      bad++; $display("FAIL left_make: got %0d want 130", kbd.outKeyboard);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL left_break: got %0d want 0", kbd.outKeyboard);
    end
    send_byte(8'h6B);
    total++;
    if (kbd.outKeyboard !== 16'd52) begin
      bad++; $display("FAIL kp4_make: got %0d want 52", kbd.outKeyboard);
    end
    send_byte(8'hF0); send_byte(8'h6B);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL kp4_break: got %0d want 0", kbd.outKeyboard);
    end
  endtask

  task automatic test_last_wins();
    send_byte(8'h1C);
    send_byte(8'h32);
    total++;
    if (kbd.outKeyboard !== 16'(B_CODE)) begin
      bad++; $display("FAIL second_make: got %0d want %0d", kbd.outKeyboard, B_CODE);
    end
    send_byte(8'hF0); send_byte(8'h1C);
    total++;
    if (kbd.outKeyboard !== 16'(B_CODE)) begin
      bad++; $display("FAIL old_break: got %0d want %0d", kbd.outKeyboard, B_CODE);
    end
    send_byte(8'hF0); send_byte(8'h32);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL new_break: got %0d want 0", kbd.outKeyboard);
    end
  endtask

  task automatic test_parity_err();
    int e0c = err_cycles;
    int l0 = err_long;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    wait_clk(20);
    @(negedge clk);
    total++;
    if (err_cycles - e0c != 1 || err_long != l0) begin
      bad++; $display("FAIL parity_pulse: got %0d cycles (%0d long) want 1 (0)",
                      err_cycles - e0c, err_long - l0);
    end
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL parity_out: got %0d want 0", kbd.outKeyboard);
    end
    send_byte(8'h1C);
    total++;
    if (kbd.outKeyboard !== 16'(A_CODE)) begin
      bad++; $display("FAIL parity_recover: got %0d want %0d", kbd.outKeyboard, A_CODE);
    end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_start_err();
    int e0c = err_cycles;
    kbd.ps2Data = 1'b1;
    wait_clk(HALF);
    kbd.ps2Clk = 1'b0;
    wait_clk(HALF);
    kbd.ps2Clk = 1'b1;
    wait_clk(20);
    @(negedge clk);
    total++;
    if (err_cycles - e0c != 1) begin
      bad++; $display("FAIL start_err: got %0d err cycles want 1", err_cycles - e0c);
    end
    send_byte(8'h5A);
    total++;
    if (kbd.outKeyboard !== 16'd128) begin
      bad++; $display("FAIL after_start_err: got %0d want 128", kbd.outKeyboard);
    end
    send_byte(8'hF0); send_byte(8'h5A);
  endtask

  task automatic test_timeout();
    int e0c = err_cycles;
    send_frame(8'h33, 1'b0, 1'b0, 5);
    wait_clk(TO + 100);
    @(negedge clk);
    total++;
    if (err_cycles - e0c != 1) begin
      bad++; $display("FAIL timeout_pulse: got %0d err cycles want 1", err_cycles - e0c);
    end
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL timeout_out: got %0d want 0", kbd.outKeyboard);
    end
    send_byte(8'h5A);
    total++;
    if (kbd.outKeyboard !== 16'd128) begin
      bad++; $display("FAIL timeout_recover: got %0d want 128", kbd.outKeyboard);
    end
    send_byte(8'hF0); send_byte(8'h5A);
  endtask

  task automatic test_flags_survive_error();
    int e0c = err_cycles;
    send_byte(8'hE0);
    send_frame(8'h6B, 1'b1, 1'b0, 11);
    wait_clk(20);
    send_byte(8'h6B);
    total++;
    if (kbd.outKeyboard !== 16'd130 || err_cycles - e0c != 1) begin
      bad++; $display("FAIL e0_kept: got %0d err=%0d want 130 err=1",
                      kbd.outKeyboard, err_cycles - e0c);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h1C);
    send_frame(8'h32, 1'b0, 1'b0, 4);
    @(negedge clk);
    reset = 1'b1;
    wait_clk(2);
    @(negedge clk);
    reset = 1'b0;
    m_out = 0; m_e0 = 1'b0; m_f0 = 1'b0;
`ifdef PS2_SHIFT_EN
    m_lsh = 1'b0; m_rsh = 1'b0;
`endif
    total++;
    if (kbd.outKeyboard !== 16'd0 || kbd.frameErr !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got out=%0d err=%b want 0 0",
                      kbd.outKeyboard, kbd.frameErr);
    end
    send_byte(8'h32);
    total++;
    if (kbd.outKeyboard !== 16'(B_CODE)) begin
      bad++; $display("FAIL post_reset_frame: got %0d want %0d", kbd.outKeyboard, B_CODE);
    end
    send_byte(8'hF0); send_byte(8'h32);
  endtask

  task automatic test_glitch();
    int e0c = err_cycles;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    model_byte(8'h1C);
    wait_clk(20);
    @(negedge clk);
    total++;
    if (kbd.outKeyboard !== 16'(A_CODE) || err_cycles != e0c) begin
      bad++; $display("FAIL glitch: got %0d err=%0d want %0d err=0",
                      kbd.outKeyboard, err_cycles - e0c, A_CODE);
    end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    send_byte(8'h16);
    total++;
`ifdef PS2_SHIFT_EN
    if (kbd.outKeyboard !== 16'd33) begin
      bad++; $display("FAIL shift_1: got %0d want 33", kbd.outKeyboard);
    end
`else
    if (kbd.outKeyboard !== 16'd49) begin
      bad++; $display("FAIL shift_1: got %0d want 49", kbd.outKeyboard);
    end
`endif
    send_byte(8'hF0); send_byte(8'h16);
    send_byte(8'hF0); send_byte(8'h12);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL shift_release: got %0d want 0", kbd.outKeyboard);
    end
`ifdef PS2_SHIFT_EN
    // shift pressed after the key does not change the held code
    send_byte(8'h4A);
    send_byte(8'h59);
    total++;
    if (kbd.outKeyboard !== 16'd47) begin
      bad++; $display("FAIL shift_late: got %0d want 47", kbd.outKeyboard);
    end
    send_byte(8'hF0); send_byte(8'h4A);
    send_byte(8'hF0); send_byte(8'h59);
    total++;
    if (kbd.outKeyboard !== 16'd0) begin
      bad++; $display("FAIL shift_late_rel: got %0d want 0", kbd.outKeyboard);
    end
`endif
  endtask

  task automatic test_random();
    logic [8:0] keys [12] = '{9'h01C, 9'h032, 9'h016, 9'h04A, 9'h029, 9'h05A,
                              9'h012, 9'h059, 9'h16B, 9'h175, 9'h06B, 9'h005};
    logic [8:0] k;
    int e0c = err_cycles;
    for (int n = 0; n < 30; n++) begin
      k = keys[$urandom_range(0, 11)];
      if (k[8]) send_byte(8'hE0);
      if ($urandom_range(0, 2) == 0) send_byte(8'hF0);
      send_byte(k[7:0]);
      total++;
      if (kbd.outKeyboard !== 16'(m_out)) begin
        bad++; $display("FAIL random[%0d] key=%h: got %0d want %0d",
                        n, k, kbd.outKeyboard, m_out);
      end
    end
    total++;
    if (err_cycles != e0c) begin
      bad++; $display("FAIL random_err: got %0d err cycles want 0", err_cycles - e0c);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    init_map();
    test_reset();
    test_make_break();
    test_e0();
    test_last_wins();
    test_parity_err();
    test_start_err();
    test_timeout();
    test_flags_survive_error();
    test_reset_mid_frame();
    test_glitch();
    test_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Keyboard-side source for the Hack keyboard memory map at address 24576.
- Receives PS/2 scan-code set 2 frames from the DE10 Lite PS/2 port and tracks E0/F0 prefixes.
- Translates make codes to Hack key codes. The memory decoder reads the resulting code through inKeyboard.
- Holds the code while the key is pressed and clears it to 0 on that key's release.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized ps2Clk samples required before the filtered clock changes state.
- TIMEOUT_CYCLES, 100000: clk cycles without a falling ps2Clk edge mid-frame before the frame is abandoned (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- ps2Clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2Data  input  1  raw PS/2 data pin, asynchronous.
- outKeyboard  output  16  Hack key code of the currently held key; 0 when no key is held. Connects to memory inKeyboard.
- frameErr  output  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

Behaviour:
- Clocking: single clk domain. Reset is synchronous and active-high.
- Reset values: outKeyboard=0, frameErr=0, FSM=IDLE, bit counter=0, e0Flag=0, f0Flag=0, shift state=0. The filtered clock resets to 1.
- Synchronizing: ps2Clk and ps2Data each pass through a 2-flop synchronizer. The synchronized ps2Clk then goes through the FILTER_LEN glitch filter.
- Sampling: ps2Data is sampled only on a falling edge of the filtered clock.
- Frame FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with count=0. On a falling edge with data=1, pulse frameErr and stay in IDLE.
  - DATA: shift each bit in LSB first. After 8 bits, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: data=1 and odd parity over 8 data bits + parity bit means the byte is valid. Otherwise pulse frameErr and drop the byte. In both cases return to IDLE.
  - Timeout: in DATA, PARITY or STOP, a timeout counter reloads on every falling edge. Reaching TIMEOUT_CYCLES pulses frameErr and returns to IDLE with count cleared.
- Byte decode (on a valid byte; all effects are registered and visible 1 clk after the STOP sample):
  - 0xE0: set e0Flag. No output change.
  - 0xF0: set f0Flag. No output change.
  - Any other byte: form the key identity from e0Flag and the byte, then clear both flags.
    - Break (f0Flag=1): if the key's code equals outKeyboard, set outKeyboard=0; otherwise no output change. Shift bookkeeping still applies.
    - Make (f0Flag=0): if the key is mapped, outKeyboard = its code. Unmapped keys leave the output unchanged. Typematic repeats rewrite the same value.
- Key map:
  - Letters, digits, space, and the US punctuation keys map to ASCII.
  - Enter 0x5A=128, Backspace 0x66=129, Esc 0x76=140.
  - E0 6B Left=130, E0 75 Up=131, E0 74 Right=132, E0 72 Down=133.
  - E0 6C Home=134, E0 69 End=135, E0 7D PgUp=136, E0 7A PgDn=137.
  - E0 70 Insert=138, E0 71 Delete=139.
  - F1..F12=141..152 (set-2 codes 05,06,04,0C,03,0B,83,0A,01,09,78,07).
- Shift keys: 0x12 and 0x59 are never output keys; they only update shift state (see Optional Feature).
- Boundary conditions:
  - A second make without an intervening break overwrites the output; the last key wins.
  - Releasing the earlier key afterwards does not clear the output.
  - Error or timeout mid-sequence leaves outKeyboard and both flags unchanged.
- Reset: reset in mid-frame discards the partial frame; reset wins over every simultaneous event.

Optional Feature:
- Macro: PS2_SHIFT_EN.
- Defined:
  - Left and right shift are tracked independently; shift is active if either is held.
  - Unshifted letters give 97..122. Shifted letters give 65..90.
  - Shifted digits and punctuation give US-layout symbols (e.g. shift+'1'=33, shift+'/'=63).
  - Shift state is sampled at make time. Changing shift while a key is held does not alter outKeyboard.
- Undefined:
  - No shift state exists.
  - Letters always give 65..90; digits and punctuation give their unshifted ASCII.

Test Plan:
- Valid frame for 0x1C ('A' key), then F0 1C -> outKeyboard=65 one clk after the first stop bit (97 with PS2_SHIFT_EN), then returns to 0 after the break frame. frameErr stays 0.
- E0 6B, then E0 F0 6B -> outKeyboard=130, then 0. A bare 0x6B (keypad 4) gives 52.
- Make 0x1C, then make 0x32 ('B'), then F0 1C -> output goes 65, 66, and stays 66. Then F0 32 -> 0.
- Frame 0x1C with wrong parity -> frameErr pulses exactly 1 clk and outKeyboard stays 0. A following good 0x1C gives 65.
- 5 bits sent, then the clock stalls TIMEOUT_CYCLES -> frameErr pulses and the FSM returns to IDLE. The next full frame 0x5A gives 128.
- PS2_SHIFT_EN: 12, 16, F0 16, F0 12 -> 33, then 0. A 1-cycle glitch on ps2Clk mid-frame is filtered and the byte is still decoded.
